// File: rtl/qpsk_mod_core.sv
// qpsk_mod_core
//   Captures a serial bit stream qualified by the divided bit clock clk1, which
//   is sampled as a level in the clk domain. Consecutive bits are paired into
//   I/Q dibits and Gray-mapped to one of four carrier phases. The output
//   carrier is a free-running 16-step phase accumulator rotated by 4*phase.
//
//   Build option: define QPSK_SINE_LUT_EN to drive sample_out from a 16-entry
//   sine table. When it is undefined, sample_out is a +/-127 square wave and
//   no table is built.
//
// Parameters
//   STEP_DIV     system clocks per phase step, 1..255 (carrier = 16*STEP_DIV clk)
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   clk1         divided bit clock, rising level transition marks a new bit
//   din          serial data, valid when a clk1 rise is detected
//   i_bit        I bit of the current symbol
//   q_bit        Q bit of the current symbol
//   phase        Gray-mapped phase code of the current symbol
//   sym_stb      one-clock pulse when a new symbol is loaded
//   carrier_out  square carrier, NOT of the output phase index MSB
//   sample_out   signed 8-bit carrier sample
//
// Pairing FSM
//   state     | meaning
//   ST_WAIT_I | next detected bit is stored as the pending I bit
//   ST_WAIT_Q | next detected bit is Q; the symbol is loaded with it

module qpsk_mod_core #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk1,
  input  logic       din,
  output logic       i_bit,
  output logic       q_bit,
  output logic [1:0] phase,
  output logic       sym_stb,
  output logic       carrier_out,
  output logic [7:0] sample_out
);

  typedef enum logic {
    ST_WAIT_I = 1'b0,
    ST_WAIT_Q = 1'b1
  } pair_state_t;

  localparam logic [7:0] PRESC_MAX = 8'(STEP_DIV - 1);

  pair_state_t state_q;
  logic        clk1_q;
  logic        pend_q;
  logic        i_bit_q;
  logic        q_bit_q;
  logic [1:0]  phase_q;
  logic        sym_stb_q;
  logic [3:0]  acc_q;
  logic [3:0]  acc_d;
  logic [7:0]  presc_q;
  logic [7:0]  presc_d;
  logic        carrier_q;
  logic [7:0]  sample_q;
  logic [7:0]  sample_d;
  logic [3:0]  idx;
  logic        rise;

  assign rise = clk1 & ~clk1_q;

  // Bit pairing and symbol load. The Gray code {I, I^Q} gives
  // 00->0, 01->1, 11->2, 10->3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_WAIT_I;
      clk1_q    <= 1'b0;
      pend_q    <= 1'b0;
      i_bit_q   <= 1'b0;
      q_bit_q   <= 1'b0;
      phase_q   <= 2'd0;
      sym_stb_q <= 1'b0;
    end else begin
      clk1_q    <= clk1;
      sym_stb_q <= 1'b0;
      if (rise) begin
        case (state_q)
          ST_WAIT_I: begin
            pend_q  <= din;
            state_q <= ST_WAIT_Q;
          end
          ST_WAIT_Q: begin
            i_bit_q   <= pend_q;
            q_bit_q   <= din;
            phase_q   <= {pend_q, pend_q ^ din};
            sym_stb_q <= 1'b1;
            state_q   <= ST_WAIT_I;
          end
          default: state_q <= ST_WAIT_I;
        endcase
      end
    end
  end

  // Free-running phase accumulator; symbol events never realign it.
  always_comb begin
    presc_d = presc_q + 8'd1;
    acc_d   = acc_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = 8'd0;
      acc_d   = acc_q + 4'd1;
    end
  end

  // A new phase shifts idx in the same cycle; 4 steps = 90 degrees.
  assign idx = acc_q + {phase_q, 2'b00};

`ifdef QPSK_SINE_LUT_EN
  always_comb begin
    sample_d = 8'h00;
    case (idx)
      4'd0:  sample_d = 8'h00;
      4'd1:  sample_d = 8'h31;
      4'd2:  sample_d = 8'h5A;
      4'd3:  sample_d = 8'h75;
      4'd4:  sample_d = 8'h7F;
      4'd5:  sample_d = 8'h75;
      4'd6:  sample_d = 8'h5A;
      4'd7:  sample_d = 8'h31;
      4'd8:  sample_d = 8'h00;
      4'd9:  sample_d = 8'hCF;
      4'd10: sample_d = 8'hA6;
      4'd11: sample_d = 8'h8B;
      4'd12: sample_d = 8'h81;
      4'd13: sample_d = 8'h8B;
      4'd14: sample_d = 8'hA6;
      4'd15: sample_d = 8'hCF;
      default: sample_d = 8'h00;
    endcase
  end
`else
  always_comb begin
    sample_d = idx[3] ? 8'h81 : 8'h7F;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= 4'd0;
      presc_q   <= 8'd0;
      carrier_q <= 1'b0;
      sample_q  <= 8'h00;
    end else begin
      acc_q     <= acc_d;
      presc_q   <= presc_d;
      carrier_q <= ~idx[3];
      sample_q  <= sample_d;
    end
  end

  assign i_bit       = i_bit_q;
  assign q_bit       = q_bit_q;
  assign phase       = phase_q;
  assign sym_stb     = sym_stb_q;
  assign carrier_out = carrier_q;
  assign sample_out  = sample_q;

endmodule
